// File: rtl/uart_pkg.sv
// Shared constants, state types and CRC helper for the framed UART receiver.
package uart_pkg;

   localparam logic [7:0]  SYNC_BYTE = 8'hFE;
   localparam logic [31:0] CRC_POLY  = 32'h04C1_1DB7;
   localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
   localparam int          CRC_BYTES = 4;

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_OPT,
      ST_LEN,
      ST_DATA,
      ST_CSM,
      ST_CHECK
   } rx_state_e;

   typedef enum logic [1:0] {
      BS_IDLE,
      BS_START,
      BS_DATA,
      BS_STOP
   } bit_state_e;

   // One bit of a non-reflected MSB-first CRC-32 shift register.
   function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic din);
      logic fb;
      fb = crc[31] ^ din;
      return {crc[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// Serial byte receiver: input synchronizer, start-bit qualification, LSB-first shift and stop check.
// With UART_RX_TIMEOUT_EN defined, an extra start_o pulse marks every qualified falling edge.
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int BYTE_SIZE    = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rx_i,
`ifdef UART_RX_TIMEOUT_EN
   output logic                 start_o,
`endif
   output logic                 byte_valid_o,
   output logic [BYTE_SIZE-1:0] byte_o,
   output logic                 stop_err_o
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(BYTE_SIZE + 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTE_SIZE - 1);

   logic                 sync1_q, sync2_q, prev_q;
   bit_state_e           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [BYTE_SIZE-1:0] shift_q, shift_d;
   logic                 start_det;

   // Flops reset to the idle-high line level so reset release never looks like a start bit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= rx_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign start_det = (state_q == BS_IDLE) && prev_q && !sync2_q;

`ifdef UART_RX_TIMEOUT_EN
   assign start_o = start_det;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + CNT_W'(1);
      idx_d        = idx_q;
      shift_d      = shift_q;
      byte_valid_o = 1'b0;
      stop_err_o   = 1'b0;
      unique case (state_q)
         BS_IDLE: begin
            cnt_d = '0;
            if (start_det) begin
               state_d = BS_START;
            end
         end
         BS_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = sync2_q ? BS_IDLE : BS_DATA;
            end
         end
         BS_DATA: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d   = '0;
               shift_d = {sync2_q, shift_q[BYTE_SIZE-1:1]};
               idx_d   = idx_q + IDX_W'(1);
               if (idx_q == IDX_LAST) begin
                  state_d = BS_STOP;
               end
            end
         end
         BS_STOP: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d        = '0;
               state_d      = BS_IDLE;
               byte_valid_o = sync2_q;
               stop_err_o   = !sync2_q;
            end
         end
         default: begin
            state_d = BS_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= BS_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   assign byte_o = shift_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Framed UART receiver: sync/opt/len/data/CRC-32 parser with a held output register.
// Defining UART_RX_TIMEOUT_EN adds an inter-byte timeout that aborts a stalled frame.
module uart_frame_rx
   import uart_pkg::*;
#(
   parameter int FULL_DATA_SIZE = 40,
   parameter int BYTE_SIZE      = 8,
   parameter int CLKS_PER_BIT   = 16,
   parameter int TIMEOUT_BITS   = 32
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      in_bit,
   output logic [FULL_DATA_SIZE-1:0] full_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      crc_err,
   output logic                      fmt_err,
   output logic                      ovr_err
);

   localparam int USEFUL  = FULL_DATA_SIZE - 2 * BYTE_SIZE;
   localparam int MAX_LEN = USEFUL / BYTE_SIZE;
   localparam int CRC_W   = 32;
   localparam logic [BYTE_SIZE-1:0] MAX_LEN_B  = BYTE_SIZE'(MAX_LEN);
   localparam logic [BYTE_SIZE-1:0] CRC_LAST_B = BYTE_SIZE'(CRC_BYTES - 1);

   if (CLKS_PER_BIT < 4 || TIMEOUT_BITS < 1) begin : g_cfg_check
      $error("uart_frame_rx: CLKS_PER_BIT must be at least 4 and TIMEOUT_BITS at least 1");
   end

   logic                      byte_valid;
   logic                      stop_err;
   logic [BYTE_SIZE-1:0]      rx_byte;
   logic                      tmo_hit;

   rx_state_e                 state_q, state_d;
   logic [BYTE_SIZE-1:0]      opt_q, opt_d;
   logic [BYTE_SIZE-1:0]      len_q, len_d;
   logic [BYTE_SIZE-1:0]      bcnt_q, bcnt_d;
   logic [USEFUL-1:0]         data_q, data_d;
   logic [CRC_W-1:0]          crc_q, crc_d, crc_byte;
   logic [CRC_W-1:0]          crc_rx_q, crc_rx_d;
   logic [FULL_DATA_SIZE-1:0] full_data_q, full_data_d;
   logic                      out_valid_q, out_valid_d;
   logic                      crc_err_q, crc_err_d;
   logic                      fmt_err_q, fmt_err_d;
   logic                      ovr_err_q, ovr_err_d;

`ifdef UART_RX_TIMEOUT_EN
   localparam int TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TMO_W      = $clog2(TMO_CYCLES + 1);

   logic             rx_start;
   logic [TMO_W-1:0] tmo_q, tmo_d;

   uart_byte_rx #(
      .BYTE_SIZE    (BYTE_SIZE),
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_byte_rx (
      .clk_i        (CLK),
      .rst_ni       (RST),
      .rx_i         (in_bit),
      .start_o      (rx_start),
      .byte_valid_o (byte_valid),
      .byte_o       (rx_byte),
      .stop_err_o   (stop_err)
   );

   // Idle time is measured from the last start bit; hunting for sync never times out.
   always_comb begin
      tmo_d = tmo_q + TMO_W'(1);
      if (state_q == ST_HUNT || rx_start) begin
         tmo_d = '0;
      end
   end

   assign tmo_hit = (state_q != ST_HUNT) && (tmo_q == TMO_W'(TMO_CYCLES - 1));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   uart_byte_rx #(
      .BYTE_SIZE    (BYTE_SIZE),
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_byte_rx (
      .clk_i        (CLK),
      .rst_ni       (RST),
      .rx_i         (in_bit),
      .byte_valid_o (byte_valid),
      .byte_o       (rx_byte),
      .stop_err_o   (stop_err)
   );

   assign tmo_hit = 1'b0;
`endif

   // Bits enter the CRC in line order, i.e. LSB of each byte first.
   always_comb begin
      crc_byte = crc_q;
      for (int b = 0; b < BYTE_SIZE; b++) begin
         crc_byte = crc32_step(crc_byte, rx_byte[b]);
      end
   end

   always_comb begin
      state_d     = state_q;
      opt_d       = opt_q;
      len_d       = len_q;
      bcnt_d      = bcnt_q;
      data_d      = data_q;
      crc_d       = crc_q;
      crc_rx_d    = crc_rx_q;
      full_data_d = full_data_q;
      out_valid_d = out_valid_q && !out_ready;
      crc_err_d   = 1'b0;
      fmt_err_d   = 1'b0;
      ovr_err_d   = 1'b0;
      if (stop_err || tmo_hit) begin
         fmt_err_d = 1'b1;
         state_d   = ST_HUNT;
      end else begin
         unique case (state_q)
            ST_HUNT: begin
               if (byte_valid && rx_byte == SYNC_BYTE) begin
                  state_d = ST_OPT;
                  crc_d   = CRC_INIT;
                  data_d  = '0;
               end
            end
            ST_OPT: begin
               if (byte_valid) begin
                  opt_d   = rx_byte;
                  crc_d   = crc_byte;
                  state_d = ST_LEN;
               end
            end
            ST_LEN: begin
               if (byte_valid) begin
                  len_d  = rx_byte;
                  crc_d  = crc_byte;
                  bcnt_d = '0;
                  if (rx_byte == '0 || rx_byte > MAX_LEN_B) begin
                     fmt_err_d = 1'b1;
                     state_d   = ST_HUNT;
                  end else begin
                     state_d = ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (byte_valid) begin
                  crc_d = crc_byte;
                  for (int i = 0; i < MAX_LEN; i++) begin
                     if (bcnt_q == BYTE_SIZE'(i)) begin
                        data_d[USEFUL-1-BYTE_SIZE*i -: BYTE_SIZE] = rx_byte;
                     end
                  end
                  if (bcnt_q == len_q - BYTE_SIZE'(1)) begin
                     bcnt_d  = '0;
                     state_d = ST_CSM;
                  end else begin
                     bcnt_d = bcnt_q + BYTE_SIZE'(1);
                  end
               end
            end
            ST_CSM: begin
               if (byte_valid) begin
                  crc_rx_d = {crc_rx_q[CRC_W-BYTE_SIZE-1:0], rx_byte};
                  if (bcnt_q == CRC_LAST_B) begin
                     bcnt_d  = '0;
                     state_d = ST_CHECK;
                  end else begin
                     bcnt_d = bcnt_q + BYTE_SIZE'(1);
                  end
               end
            end
            ST_CHECK: begin
               state_d = ST_HUNT;
               if (crc_rx_q != crc_q) begin
                  crc_err_d = 1'b1;
               end else if (!out_valid_q || out_ready) begin
                  full_data_d = {opt_q, len_q, data_q};
                  out_valid_d = 1'b1;
               end else begin
                  ovr_err_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_HUNT;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= ST_HUNT;
         opt_q       <= '0;
         len_q       <= '0;
         bcnt_q      <= '0;
         data_q      <= '0;
         crc_q       <= '0;
         crc_rx_q    <= '0;
         full_data_q <= '0;
         out_valid_q <= 1'b0;
         crc_err_q   <= 1'b0;
         fmt_err_q   <= 1'b0;
         ovr_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         opt_q       <= opt_d;
         len_q       <= len_d;
         bcnt_q      <= bcnt_d;
         data_q      <= data_d;
         crc_q       <= crc_d;
         crc_rx_q    <= crc_rx_d;
         full_data_q <= full_data_d;
         out_valid_q <= out_valid_d;
         crc_err_q   <= crc_err_d;
         fmt_err_q   <= fmt_err_d;
         ovr_err_q   <= ovr_err_d;
      end
   end

   assign full_data = full_data_q;
   assign out_valid = out_valid_q;
   assign crc_err   = crc_err_q;
   assign fmt_err   = fmt_err_q;
   assign ovr_err   = ovr_err_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: directed serial frames checked against a frame/CRC model.
// Defining UART_RX_TIMEOUT_EN also exercises the inter-byte timeout.
module tb_uart_frame_rx;

   localparam int CPB   = 16;
   localparam int K_OUT = 0;
   localparam int K_CRC = 1;
   localparam int K_FMT = 2;
   localparam int K_OVR = 3;

   logic        clk      = 1'b0;
   logic        rstN     = 1'b0;
   logic        inBit    = 1'b1;
   logic        outReady = 1'b1;
   logic [39:0] fullData;
   logic        outValid;
   logic        crcErr;
   logic        fmtErr;
   logic        ovrErr;

   int          passCount  = 0;
   int          checkCount = 0;
   int          expKind[$];
   logic [39:0] expData[$];
   logic        prevValid = 1'b0;
   logic        prevReady = 1'b0;
   logic [39:0] heldData  = '0;
   logic [7:0]  d[$];
   logic [39:0] frameA;

   uart_frame_rx #(
      .FULL_DATA_SIZE (40),
      .BYTE_SIZE      (8),
      .CLKS_PER_BIT   (CPB),
      .TIMEOUT_BITS   (32)
   ) dut (
      .CLK       (clk),
      .RST       (rstN),
      .in_bit    (inBit),
      .full_data (fullData),
      .out_valid (outValid),
      .out_ready (outReady),
      .crc_err   (crcErr),
      .fmt_err   (fmtErr),
      .ovr_err   (ovrErr)
   );

   always #5 clk = ~clk;

   // Reference CRC: walk the message bit by bit in line order (LSB of each byte first).
   function automatic logic [31:0] crcModel(input logic [7:0] msg[$]);
      logic        bits[$];
      logic [31:0] r;
      logic        b;
      r = 32'hFFFF_FFFF;
      foreach (msg[j]) for (int i = 0; i < 8; i++) bits.push_back(msg[j][i]);
      while (bits.size() > 0) begin
         b = bits.pop_front();
         r = (r[31] ^ b) ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
      end
      return r;
   endfunction

   function automatic logic [39:0] frameModel(input logic [7:0] opt, input logic [7:0] len,
                                              input logic [7:0] data[$]);
      logic [39:0] f;
      f = {opt, len, 24'h0};
      foreach (data[k]) f[23-8*k -: 8] = data[k];
      return f;
   endfunction

   task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] req);
      checkCount++;
      if (act === req) passCount++;
      else $display("[TB] FAIL %s: got %h, required %h", name, act, req);
   endtask

   task automatic takeEvent(input int kind, input string name, input logic [39:0] act);
      int          k;
      logic [39:0] e;
      if (expKind.size() == 0) begin
         checkCount++;
         $display("[TB] FAIL %s: unexpected event (data %h), required none", name, act);
      end else begin
         k = expKind.pop_front();
         e = expData.pop_front();
         checkOutput({name, " kind"}, 40'(kind), 40'(k));
         if (kind == K_OUT && k == K_OUT) checkOutput({name, " data"}, act, e);
      end
   endtask

   // Compare process: every output event must match the next expected event in order.
   initial begin
      forever begin
         @(negedge clk);
         if (!rstN) begin
            prevValid = 1'b0;
            prevReady = 1'b0;
         end else begin
            if (outValid) begin
               if (!prevValid || prevReady) takeEvent(K_OUT, "frame out", fullData);
               else checkOutput("held data stable", fullData, heldData);
               heldData = fullData;
            end
            if (crcErr) takeEvent(K_CRC, "crc_err pulse", fullData);
            if (fmtErr) takeEvent(K_FMT, "fmt_err pulse", fullData);
            if (ovrErr) takeEvent(K_OVR, "ovr_err pulse", fullData);
            prevValid = outValid;
            prevReady = outReady;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic sendByte(input logic [7:0] b, input logic stopBit);
      inBit = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         inBit = b[i];
         tick(CPB);
      end
      inBit = stopBit;
      tick(CPB);
      inBit = 1'b1;
   endtask

   task automatic applyStimulus(input logic [7:0] opt, input logic [7:0] len,
                                input logic [7:0] data[$], input int kind, input bit flipCrc);
      logic [7:0]  body[$];
      logic [31:0] crc;
      body = data;
      body.push_front(len);
      body.push_front(opt);
      crc = crcModel(body);
      if (flipCrc) crc[0] = ~crc[0];
      expKind.push_back(kind);
      expData.push_back(frameModel(opt, len, data));
      sendByte(8'hFE, 1'b1);
      foreach (body[i]) sendByte(body[i], 1'b1);
      for (int i = 3; i >= 0; i--) sendByte(crc[8*i +: 8], 1'b1);
   endtask

   task automatic waitDrain(input string name, input int maxCycles);
      int n;
      n = 0;
      while (expKind.size() != 0 && n < maxCycles) begin
         tick(1);
         n++;
      end
      checkOutput({name, " pending events"}, 40'(expKind.size()), 40'd0);
      expKind.delete();
      expData.delete();
      tick(2 * CPB);
   endtask

   initial begin
      tick(4);
      checkOutput("reset full_data", fullData, 40'h0);
      checkOutput("reset out_valid", 40'(outValid), 40'h0);
      checkOutput("reset errors", 40'({crcErr, fmtErr, ovrErr}), 40'h0);
      rstN = 1'b1;
      tick(5);

      d.delete(); d.push_back(8'h12); d.push_back(8'h34);
      checkOutput("model frame A5/02", frameModel(8'hA5, 8'h02, d), 40'hA5_02_1234_00);
      applyStimulus(8'hA5, 8'h02, d, K_OUT, 1'b0);
      waitDrain("good frame", 400);
      checkOutput("valid after single handshake", 40'(outValid), 40'h0);

      applyStimulus(8'hA5, 8'h02, d, K_CRC, 1'b1);
      waitDrain("bad crc", 400);
      checkOutput("no output on bad crc", 40'(outValid), 40'h0);
      d.delete(); d.push_back(8'h01); d.push_back(8'h02); d.push_back(8'h03);
      applyStimulus(8'h3C, 8'h03, d, K_OUT, 1'b0);
      waitDrain("frame after bad crc", 400);

      sendByte(8'h00, 1'b1);
      sendByte(8'hFF, 1'b1);
      sendByte(8'h7E, 1'b1);
      d.delete(); d.push_back(8'hC3);
      checkOutput("model frame 07/01", frameModel(8'h07, 8'h01, d), 40'h07_01_C300_00);
      applyStimulus(8'h07, 8'h01, d, K_OUT, 1'b0);
      waitDrain("frame after garbage", 400);

      expKind.push_back(K_FMT); expData.push_back('0);
      sendByte(8'hFE, 1'b1);
      sendByte(8'h07, 1'b1);
      sendByte(8'h04, 1'b1);
      waitDrain("len too big", 400);
      d.delete(); d.push_back(8'h55); d.push_back(8'hAA);
      applyStimulus(8'h99, 8'h02, d, K_OUT, 1'b0);
      waitDrain("frame after bad len", 400);

      expKind.push_back(K_FMT); expData.push_back('0);
      sendByte(8'hFE, 1'b1);
      sendByte(8'h22, 1'b1);
      sendByte(8'h01, 1'b0);
      waitDrain("stop bit low", 400);
      d.delete(); d.push_back(8'hE1);
      applyStimulus(8'h22, 8'h01, d, K_OUT, 1'b0);
      waitDrain("frame after stop error", 400);

      outReady = 1'b0;
      d.delete(); d.push_back(8'h10); d.push_back(8'h20); d.push_back(8'h30);
      frameA = frameModel(8'h01, 8'h03, d);
      applyStimulus(8'h01, 8'h03, d, K_OUT, 1'b0);
      d.delete(); d.push_back(8'h77);
      applyStimulus(8'h02, 8'h01, d, K_OVR, 1'b0);
      waitDrain("back-to-back held", 400);
      checkOutput("held frame data", fullData, 40'h01_03_102030);
      checkOutput("held frame matches model", fullData, frameA);
      checkOutput("held out_valid", 40'(outValid), 40'h1);
      outReady = 1'b1;
      tick(2);
      checkOutput("released out_valid", 40'(outValid), 40'h0);

      d.delete(); d.push_back(8'h11); d.push_back(8'h22);
      applyStimulus(8'h44, 8'h02, d, K_OUT, 1'b0);
      waitDrain("frame before reset", 400);
      sendByte(8'hFE, 1'b1);
      sendByte(8'h07, 1'b1);
      sendByte(8'h02, 1'b1);
      sendByte(8'h11, 1'b1);
      inBit = 1'b0;
      tick(20);
      rstN = 1'b0;
      tick(2);
      checkOutput("mid-data reset full_data", fullData, 40'h0);
      checkOutput("mid-data reset out_valid", 40'(outValid), 40'h0);
      inBit = 1'b1;
      tick(3);
      rstN = 1'b1;
      tick(3 * CPB);
      checkOutput("after reset errors", 40'({crcErr, fmtErr, ovrErr, outValid}), 40'h0);
      d.delete(); d.push_back(8'h5A);
      applyStimulus(8'h66, 8'h01, d, K_OUT, 1'b0);
      waitDrain("frame after reset", 400);

`ifdef UART_RX_TIMEOUT_EN
      expKind.push_back(K_FMT); expData.push_back('0);
      sendByte(8'hFE, 1'b1);
      sendByte(8'h07, 1'b1);
      sendByte(8'h02, 1'b1);
      waitDrain("inter-byte timeout", 40 * CPB);
      d.delete(); d.push_back(8'h0F);
      applyStimulus(8'h08, 8'h01, d, K_OUT, 1'b0);
      waitDrain("frame after timeout", 400);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
